// File: rtl/bus_xfer_ctrl.sv
// Register-transfer sequencer: IDLE -> SETUP -> XFER -> DONE, driving rs1/rs2/ws1/im to NREG registers.
// Optional macro BUS_CAPTURE_EN enables OUT (bus -> out_data); without it OUT runs as a NOP.
module bus_xfer_ctrl #(
   parameter int NREG = 4,
   parameter int W    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [1:0]      op,
   input  logic [1:0]      src,
   input  logic [1:0]      dst,
   input  logic [W-1:0]    imm,
   input  logic [W-1:0]    bus,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [W-1:0]    im,
   output logic [NREG-1:0] rs1,
   output logic [NREG-1:0] rs2,
   output logic [NREG-1:0] ws1,
   output logic [W-1:0]    out_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_XFER  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_MOV = 2'b10;
   localparam logic [1:0] OP_OUT = 2'b11;

   state_t         state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic [1:0]     src_q, src_d;
   logic [1:0]     dst_q, dst_d;
   logic [W-1:0]   imm_q, imm_d;
   logic           ill_q, ill_d;
   logic [1:0]     op_eff;

   // Only the operands an op actually uses can make it illegal.
   function automatic logic cmd_illegal(input logic [1:0] c_op, input logic [1:0] c_src,
                                        input logic [1:0] c_dst);
      logic src_bad;
      logic dst_bad;
      src_bad = (int'(c_src) >= NREG);
      dst_bad = (int'(c_dst) >= NREG);
      case (c_op)
         OP_LDI:  cmd_illegal = dst_bad;
         OP_MOV:  cmd_illegal = src_bad || dst_bad || (c_src == c_dst);
         OP_OUT:  cmd_illegal = src_bad;
         default: cmd_illegal = 1'b0;
      endcase
   endfunction

`ifdef BUS_CAPTURE_EN
   assign op_eff = op;
`else
   assign op_eff = (op == OP_OUT) ? OP_NOP : op;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      src_d   = src_q;
      dst_d   = dst_q;
      imm_d   = imm_q;
      ill_d   = ill_q;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      im      = '0;
      rs1     = '0;
      rs2     = '0;
      ws1     = '0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_SETUP;
               op_d    = op_eff;
               src_d   = src;
               dst_d   = dst;
               imm_d   = imm;
               ill_d   = cmd_illegal(op_eff, src, dst);
            end
         end
         S_SETUP: begin
            state_d = S_XFER;
            busy    = 1'b1;
            if (!ill_q) begin
               if (op_q == OP_MOV || op_q == OP_OUT) ws1 = NREG'(1) << src_q;
               if (op_q == OP_LDI)                   im  = imm_q;
            end
         end
         S_XFER: begin
            state_d = S_DONE;
            busy    = 1'b1;
            if (!ill_q) begin
               case (op_q)
                  OP_MOV: begin
                     ws1 = NREG'(1) << src_q;
                     rs2 = NREG'(1) << dst_q;
                  end
                  OP_OUT: ws1 = NREG'(1) << src_q;
                  OP_LDI: begin
                     im  = imm_q;
                     rs1 = NREG'(1) << dst_q;
                  end
                  default: ;
               endcase
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy    = 1'b1;
            done    = 1'b1;
            err     = ill_q;
         end
         default: state_d = S_IDLE;
      endcase
      // Reset kills strobes in the current cycle so an aborted transfer never writes its destination.
      if (rst) begin
         im  = '0;
         rs1 = '0;
         rs2 = '0;
         ws1 = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         src_q   <= '0;
         dst_q   <= '0;
         imm_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         imm_q   <= imm_d;
         ill_q   <= ill_d;
      end
   end

`ifdef BUS_CAPTURE_EN
   logic [W-1:0] out_data_q, out_data_d;

   always_comb begin
      out_data_d = out_data_q;
      if (state_q == S_XFER && op_q == OP_OUT && !ill_q) out_data_d = bus;
   end

   always_ff @(posedge clk) begin
      if (rst) out_data_q <= '0;
      else     out_data_q <= out_data_d;
   end

   assign out_data = out_data_q;
`else
   logic unused_bus;
   assign unused_bus = ^bus;
   assign out_data   = '0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: register-file model on the bus, per-command reference model, random commands.
module tb_bus_xfer_ctrl;
   localparam int NREG = 4;
   localparam int W    = 4;
`ifdef BUS_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst, req;
   logic [1:0]      op, src, dst;
   logic [W-1:0]    imm, bus;
   logic            busy, done, err;
   logic [W-1:0]    im, out_data;
   logic [NREG-1:0] rs1, rs2, ws1;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] rf [NREG];
   logic         rf_init;
   logic [W-1:0] exp_rf [NREG];
   logic [W-1:0] exp_out;

   bus_xfer_ctrl #(.NREG(NREG), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .src(src), .dst(dst), .imm(imm), .bus(bus),
      .busy(busy), .done(done), .err(err), .im(im), .rs1(rs1), .rs2(rs2), .ws1(ws1),
      .out_data(out_data)
   );

   always #5 clk = ~clk;

   // Register file: the selected register drives the bus; undriven bus floats to a junk pattern.
   always_comb begin
      bus = 4'h5;
      for (int i = 0; i < NREG; i++) if (ws1[i]) bus = rf[i];
   end

   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rf_init)     rf[i] <= '0;
         else if (rs1[i]) rf[i] <= im;
         else if (rs2[i]) rf[i] <= bus;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
      end
   endtask

   function automatic bit legal_f(input logic [1:0] c_op, input logic [1:0] c_src,
                                  input logic [1:0] c_dst);
      case (c_op)
         2'b01:   return int'(c_dst) < NREG;
         2'b10:   return (c_src != c_dst) && int'(c_src) < NREG && int'(c_dst) < NREG;
         2'b11:   return CAP ? (int'(c_src) < NREG) : 1'b1;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk_outputs(input string tag, input logic e_busy, input logic e_done,
                              input logic e_err, input logic [W-1:0] e_im,
                              input logic [NREG-1:0] e_rs1, input logic [NREG-1:0] e_rs2,
                              input logic [NREG-1:0] e_ws1);
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(done), 32'(e_done));
      chk({tag, ".err"},  32'(err),  32'(e_err));
      chk({tag, ".im"},   32'(im),   32'(e_im));
      chk({tag, ".rs1"},  32'(rs1),  32'(e_rs1));
      chk({tag, ".rs2"},  32'(rs2),  32'(e_rs2));
      chk({tag, ".ws1"},  32'(ws1),  32'(e_ws1));
      chk({tag, ".out"},  32'(out_data), 32'(exp_out));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rf(input string tag);
      for (int i = 0; i < NREG; i++) chk($sformatf("%s.rf%0d", tag, i), 32'(rf[i]), 32'(exp_rf[i]));
   endtask

   // One full command, phase by phase; req and fields are scrambled while busy to show they are ignored.
   task automatic run_cmd(input logic [1:0] c_op, input logic [1:0] c_src, input logic [1:0] c_dst,
                          input logic [W-1:0] c_imm);
      bit                legal, is_ldi, is_mov, drv;
      logic [W-1:0]      e_im;
      logic [NREG-1:0]   s_src, s_dst;
      string             t;
      legal  = legal_f(c_op, c_src, c_dst);
      is_ldi = legal && c_op == 2'b01;
      is_mov = legal && c_op == 2'b10;
      drv    = legal && (c_op == 2'b10 || (c_op == 2'b11 && CAP));
      e_im   = is_ldi ? c_imm : '0;
      s_src  = NREG'(1) << c_src;
      s_dst  = NREG'(1) << c_dst;
      t      = $sformatf("op%0d_s%0d_d%0d", c_op, c_src, c_dst);

      chk_outputs({t, ".idle"}, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      req = 1'b1; op = c_op; src = c_src; dst = c_dst; imm = c_imm;
      tick();
      chk_outputs({t, ".setup"}, 1'b1, 1'b0, 1'b0, e_im, '0, '0, drv ? s_src : '0);
      req = 1'($urandom); op = 2'($urandom); src = 2'($urandom); dst = 2'($urandom); imm = 4'($urandom);
      tick();
      chk_outputs({t, ".xfer"}, 1'b1, 1'b0, 1'b0, e_im, is_ldi ? s_dst : '0,
                  is_mov ? s_dst : '0, drv ? s_src : '0);
      req = 1'($urandom); op = 2'($urandom); src = 2'($urandom); dst = 2'($urandom);
      tick();
      if (is_ldi) exp_rf[c_dst] = c_imm;
      if (is_mov) exp_rf[c_dst] = exp_rf[c_src];
      if (legal && c_op == 2'b11 && CAP) exp_out = exp_rf[c_src];
      chk_outputs({t, ".done"}, 1'b1, 1'b1, !legal, '0, '0, '0, '0);
      req = 1'($urandom);
      tick();
      chk_rf(t);
   endtask

   initial begin
      rst = 1'b1; rf_init = 1'b1; req = 1'b1;
      op = 2'b01; src = 2'd0; dst = 2'd0; imm = 4'b1001;
      exp_out = '0;
      for (int i = 0; i < NREG; i++) exp_rf[i] = '0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk_outputs($sformatf("reset%0d", c), 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      end
      rst = 1'b0; rf_init = 1'b0;

      run_cmd(2'b01, 2'd0, 2'd0, 4'b1001);
      run_cmd(2'b01, 2'd0, 2'd1, 4'b0110);
      run_cmd(2'b10, 2'd1, 2'd0, 4'h0);
      run_cmd(2'b01, 2'd0, 2'd2, 4'b1100);
      run_cmd(2'b11, 2'd2, 2'd0, 4'h0);
      chk("out_after_out", 32'(out_data), CAP ? 32'hC : 32'h0);
      run_cmd(2'b10, 2'd3, 2'd3, 4'h0);
      run_cmd(2'b00, 2'd1, 2'd2, 4'h7);
      run_cmd(2'b01, 2'd0, 2'd0, 4'b0011);

      // Reset in XFER of MOV B->A: A must keep its old value.
      req = 1'b1; op = 2'b10; src = 2'd1; dst = 2'd0; imm = '0;
      tick();
      req = 1'b0;
      tick();
      chk("abort.xfer_rs2", 32'(rs2), 32'b0001);
      rst = 1'b1;
      #2;
      chk("abort.rs2_gated", 32'(rs2), 32'h0);
      tick();
      rst = 1'b0;
      exp_out = '0;
      chk_outputs("abort.after", 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      chk("abort.a_kept", 32'(rf[0]), 32'b0011);
      tick();

      for (int n = 0; n < 60; n++)
         run_cmd(2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
